// File: rtl/vs_ring_pkg.sv
// Shared constants and types for the value-storage ring buffer.
package vs_ring_pkg;

  // Register offsets within the responder window
  localparam logic [1:0] VS_INDIRECT = 2'd0;
  localparam logic [1:0] VS_STATUS   = 2'd1;
  localparam logic [1:0] VS_DROPPED  = 2'd2;

  // Command words written to INDIRECT
  localparam logic [15:0] VS_FREEZE   = 16'h0000;
  localparam logic [15:0] VS_UNFREEZE = 16'hffff;

  // Read word layout: bit 15 flags the last (or absent) entry
  localparam int          VS_LAST_BIT   = 15;
  localparam logic [15:0] VS_EMPTY_WORD = 16'h8000;

  // Bus request handshake states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_ACK    = 2'd2
  } vs_state_e;

  // Saturating increment for the dropped-sample counter
  function automatic logic [15:0] vs_sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vs_ring_ram.sv
// Simple dual-port sample memory: one write port, registered read port.
module vs_ring_ram #(
  parameter int DEPTH_BITS = 8,
  parameter int DATA_W     = 15
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_BITS];

  // Write port and registered read port; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vs_ring_buffer.sv
// Wishbone responder exposing a freezable circular sample history
// through one indirect register, plus STATUS and DROPPED counters.
module vs_ring_buffer
  import vs_ring_pkg::*;
#(
  parameter int DEPTH_BITS = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        sample_valid_i,
  input  logic [14:0] sample_dat_i,
  output logic        frozen_o
);

  localparam int CW = DEPTH_BITS + 1;
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

  vs_state_e state, state_next;

  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  frozen;
  logic [15:0]           dropped;
  logic [14:0]           rd_data;

  logic        req;
  logic        resp_ack, resp_err, resp_rd;
  logic [15:0] resp_data;
  logic        freeze_go, unfreeze_go, pop_go;
  logic        sample_store, sample_drop;

  assign req      = wb_cyc_i & wb_stb_i;
  assign frozen_o = frozen;

  // A sample is stored only while recording and no freeze/unfreeze commits this cycle
  assign sample_store = sample_valid_i & ~frozen & ~freeze_go & ~unfreeze_go;
  assign sample_drop  = sample_valid_i & (frozen | freeze_go) & ~unfreeze_go;

  vs_ring_ram #(
    .DEPTH_BITS (DEPTH_BITS),
    .DATA_W     (15)
  ) u_ram (
    .clk     (wb_clk_i),
    .wr_en   (sample_store),
    .wr_addr (wr_ptr),
    .wr_data (sample_dat_i),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Handshake state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= ST_IDLE;
    else             state <= state_next;
  end

  // Next state, response word and side-effect decode; effects commit on the edge that raises ack
  always_comb begin
    state_next  = state;
    resp_ack    = 1'b0;
    resp_err    = 1'b0;
    resp_rd     = 1'b0;
    resp_data   = '0;
    freeze_go   = 1'b0;
    unfreeze_go = 1'b0;
    pop_go      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (wb_adr_i == VS_INDIRECT && !wb_we_i) begin
            // RAM output arrives one cycle later, so wait before acking
            state_next = ST_RDWAIT;
          end else begin
            state_next = ST_ACK;
            if (wb_adr_i == 2'd3) begin
              resp_err = 1'b1;
            end else begin
              resp_ack = 1'b1;
              if (wb_we_i) begin
                if (wb_adr_i == VS_INDIRECT) begin
                  freeze_go   = (wb_dat_i == VS_FREEZE) && !frozen;
                  unfreeze_go = (wb_dat_i == VS_UNFREEZE);
                end
              end else begin
                resp_rd   = 1'b1;
                resp_data = (wb_adr_i == VS_STATUS) ? {frozen, 15'(count)} : dropped;
              end
            end
          end
        end
      end
      ST_RDWAIT: begin
        state_next = ST_ACK;
        resp_ack   = 1'b1;
        resp_rd    = 1'b1;
        if (frozen && count != '0) begin
          resp_data[VS_LAST_BIT]     = (count == CNT_ONE);
          resp_data[VS_LAST_BIT-1:0] = rd_data;
          pop_go                     = 1'b1;
        end else begin
          resp_data = VS_EMPTY_WORD;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered bus outputs; read data holds until the next read ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= resp_ack;
      wb_err_o <= resp_err;
      if (resp_rd) wb_dat_o <= resp_data;
    end
  end

  // Pointers, occupancy and freeze flag
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      frozen <= 1'b0;
    end else begin
      if (sample_store) wr_ptr <= wr_ptr + PTR_ONE;
      if (unfreeze_go) begin
        frozen <= 1'b0;
        count  <= '0;
      end else if (freeze_go) begin
        frozen <= 1'b1;
        // Oldest entry; a full buffer wraps to wr_ptr itself
        rd_ptr <= wr_ptr - count[DEPTH_BITS-1:0];
      end else if (pop_go) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        count  <= count - CNT_ONE;
      end else if (sample_store && count != CNT_FULL) begin
        count <= count + CNT_ONE;
      end
    end
  end

  // Count of samples lost while frozen
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)      dropped <= '0;
    else if (unfreeze_go) dropped <= '0;
    else if (sample_drop) dropped <= vs_sat_inc16(dropped);
  end

endmodule
